multiplicador_sequencial: RTL
=============================

# multiplicador_sequencial

Sequential 8×8 unsigned shift-and-add multiplier producing a 16-bit product. It is the inverse-operation companion of the ALU's repeated-subtraction divider and shares its start/done handshake. It occupies the multiply slot of the ALU datapath. One operand bit is processed per clock, so latency is fixed regardless of operand values.

## Interface
Parameters: none (width fixed at 8-bit operands, 16-bit product).

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
- start  in  1  request a multiplication; honoured only in IDLE
- multiplicando  in  8  unsigned operand M; latched on accepted start
- multiplicador  in  8  unsigned operand Q; latched on accepted start
- produto  out  16  registered unsigned product M×Q; holds last result
- busy  out  1  high while an operation is in progress (CALC state)
- done  out  1  one-cycle pulse: produto/flags just updated
- overflow  out  1  registered with produto; 1 when produto[15:8] ≠ 0 (result does not fit in 8 bits)
- zero  out  1  registered with produto; 1 when produto = 0

## Operation
- Internal registers:
  - A[7:0] accumulator
  - C carry bit
  - Qr[7:0] multiplier shift register
  - Mr[7:0] latched multiplicand
  - cnt[2:0] iteration counter
  - state
- States:
  - IDLE: busy=0. On start=1, latch Mr←multiplicando and Qr←multiplicador, clear A, C and cnt, then go to CALC.
  - CALC: busy=1. Each edge:
    - If Qr[0]=1, compute {C,A} = A + Mr using a 9-bit add. Otherwise {C,A} = {0,A}.
    - Shift right {C,A,Qr} by one and write it back into {A,Qr}. C is cleared.
    - cnt increments.
    - On the edge where cnt=7, also load produto←{A',Qr'} (the post-shift value) along with overflow and zero, then go to FIM.
  - FIM: done=1, busy=0, for exactly one cycle, then unconditional return to IDLE. start is ignored in FIM.
- start is ignored while in CALC or FIM. No queuing.
- Operand inputs are don't-care after the accept edge. Changes during CALC have no effect.
- Zero operands are not short-circuited. Latency is always the full 8 iterations.
- produto, overflow and zero change only on the final CALC edge. They are not cleared by a new start.
- Arithmetic is unsigned only. The 9-bit partial sum guarantees no loss of carry. Max result 255×255 = 0xFE01.

## Timing
- Reset (rst=0 at an edge): state=IDLE, produto=0x0000, busy=0, done=0, overflow=0, zero=0, and all internal registers are 0.
- Reset during CALC or FIM aborts the operation. No done pulse. The previous produto is lost (reset to 0).
- Edge E0: start accepted in IDLE.
- Edges E1..E8: 8 CALC iterations. busy=1 during the cycles between E0 and E8.
- After E8: produto valid and done=1 for one cycle. E9 returns to IDLE.
- Accept-to-done latency is 8 cycles. Fastest back-to-back rate is one operation per 10 cycles (start held high → next accept at E10).
- rst has priority over start when both are active at the same edge.

## Test plan
- Reset: rst=0 for 2 cycles → all outputs 0, busy=0, done=0.
- Basic: M=13, Q=11, 1-cycle start pulse → busy for 8 cycles, then done pulse with produto=143 (0x008F), overflow=0, zero=0.
- Maximum: M=255, Q=255 → produto=0xFE01, overflow=1, zero=0. Also M=16, Q=16 → produto=0x0100, overflow=1.
- Zero operand: M=0, Q=200 → produto=0, zero=1, overflow=0, still exactly 8 busy cycles.
- Input stability / ignored start: start with M=7, Q=9, then change inputs to M=255, Q=255 and pulse start during CALC → produto=63, and exactly one done pulse. Start held high continuously → done pulses 10 cycles apart.
- Reset mid-operation: start M=200, Q=3, then rst=0 at the 4th CALC cycle → no done pulse, produto=0. A subsequent start with M=3, Q=3 → produto=9.

Source files
------------

// File: rtl/multiplicador_sequencial.sv
// Sequential 8x8 unsigned shift-and-add multiplier with a start/done handshake.
// Consumes one multiplier bit per clock; the full 8-iteration latency is always paid.
module multiplicador_sequencial (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  multiplicando,
    input  logic [7:0]  multiplicador,
    output logic [15:0] produto,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIM  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  a_reg, a_next;
    logic [7:0]  qr_reg, qr_next;
    logic [7:0]  mr_reg, mr_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [15:0] produto_reg, produto_next;
    logic        overflow_reg, overflow_next;
    logic        zero_reg, zero_next;

    // The carry C only lives between the add and the shift, so it is bit 8 of the sum
    // and never needs to be stored across an edge.
    logic [8:0]  sum9;
    logic [7:0]  a_shift;
    logic [7:0]  q_shift;

    assign sum9    = qr_reg[0] ? ({1'b0, a_reg} + {1'b0, mr_reg}) : {1'b0, a_reg};
    assign a_shift = sum9[8:1];
    assign q_shift = {sum9[0], qr_reg[7:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            a_reg        <= 8'd0;
            qr_reg       <= 8'd0;
            mr_reg       <= 8'd0;
            cnt_reg      <= 3'd0;
            produto_reg  <= 16'd0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            a_reg        <= a_next;
            qr_reg       <= qr_next;
            mr_reg       <= mr_next;
            cnt_reg      <= cnt_next;
            produto_reg  <= produto_next;
            overflow_reg <= overflow_next;
            zero_reg     <= zero_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        a_next        = a_reg;
        qr_next       = qr_reg;
        mr_next       = mr_reg;
        cnt_next      = cnt_reg;
        produto_next  = produto_reg;
        overflow_next = overflow_reg;
        zero_next     = zero_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    mr_next    = multiplicando;
                    qr_next    = multiplicador;
                    a_next     = 8'd0;
                    cnt_next   = 3'd0;
                    state_next = CALC;
                end
            end
            CALC: begin
                a_next   = a_shift;
                qr_next  = q_shift;
                cnt_next = cnt_reg + 3'd1;
                // Last iteration: publish the post-shift {A,Qr} together with its flags.
                if (cnt_reg == 3'd7) begin
                    produto_next  = {a_shift, q_shift};
                    overflow_next = |a_shift;
                    zero_next     = ~|{a_shift, q_shift};
                    state_next    = FIM;
                end
            end
            FIM: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign produto  = produto_reg;
    assign overflow = overflow_reg;
    assign zero     = zero_reg;
    assign busy     = (state_reg == CALC);
    assign done     = (state_reg == FIM);

endmodule
